universal_shift_register: RTL and testbench
===========================================

// Module: universal_shift_register
// PURPOSE
//  Parametrised multi-mode shift register; successor to the fixed serial-in shift register.
//  Supports bidirectional shift, rotate, arithmetic right shift, parallel load and clear.
//  Also provides a saturating shifted-bit counter with FULL flag for serialiser/deserialiser framing.
//  Sits between serial links and parallel datapaths in the Proyecto1 design.
// PARAMETERS
//  WIDTH        10   register width in bits, >= 1
//  RESET_VALUE  '0   value loaded into the register on reset, WIDTH bits
// PORTS
//  CLK          in   1                     rising-edge clock
//  RST          in   1                     synchronous reset, active-high
//  ENABLE       in   1                     1 = execute MODE this cycle; 0 = hold everything
//  MODE         in   3                     operation select, see BEHAVIOUR
//  SHIFT_IN_L   in   1                     serial bit entering bit 0 on shift-left
//  SHIFT_IN_R   in   1                     serial bit entering bit WIDTH-1 on shift-right
//  LOAD_DATA    in   WIDTH                 parallel load value
//  OUT_P        out  WIDTH                 register contents
//  SHIFT_OUT_L  out  1                     OUT_P[WIDTH-1], combinational from register
//  SHIFT_OUT_R  out  1                     OUT_P[0], combinational from register
//  BIT_CNT      out  $clog2(WIDTH+1)       bits shifted in since last load/clear/reset
//  FULL         out  1                     BIT_CNT == WIDTH
// BEHAVIOUR
//  - All state updates on rising CLK. RST has priority over ENABLE and MODE.
//  - Reset values: OUT_P=RESET_VALUE, BIT_CNT=0, FULL=0.
//  - ENABLE=0: register and BIT_CNT hold, whatever MODE is.
//  - Latency: an operation issued in cycle n is visible on OUT_P after edge n+1.
//  - MODE encoding, applied when ENABLE=1 (R = register):
//    000 HOLD  R unchanged; BIT_CNT unchanged
//    001 SHL   R <= {R[WIDTH-2:0], SHIFT_IN_L}; BIT_CNT +1
//    010 SHR   R <= {SHIFT_IN_R, R[WIDTH-1:1]}; BIT_CNT +1
//    011 ROL   R <= {R[WIDTH-2:0], R[WIDTH-1]}; BIT_CNT unchanged
//    100 ROR   R <= {R[0], R[WIDTH-1:1]}; BIT_CNT unchanged
//    101 LOAD  R <= LOAD_DATA; BIT_CNT <= 0
//    110 ASR   R <= {R[WIDTH-1], R[WIDTH-1:1]}; BIT_CNT +1
//    111 CLR   R <= 0; BIT_CNT <= 0
//  - BIT_CNT saturates at WIDTH; increments at WIDTH leave it at WIDTH and FULL at 1.
//  - FULL is derived from the registered BIT_CNT; it asserts on the edge that completes the WIDTH-th shift.
//  - WIDTH=1: SHL loads SHIFT_IN_L, SHR loads SHIFT_IN_R, ROL/ROR/ASR leave R unchanged; ASR still counts.
//  - A direction change mid-frame (SHL then SHR) keeps counting; the counter does not track direction.
//  - RST asserted mid-operation: the next edge restores the reset values regardless of ENABLE/MODE.
//  - SHIFT_OUT_L/R track the register with no extra delay; they equal bits of OUT_P.
// CONFIGURATION
//  PARITY_EN defined: adds output PARITY (1 bit) = ^OUT_P, registered together with R.
//    Reset value 0 for RESET_VALUE=0. In general PARITY reset value = ^RESET_VALUE.
//    PARITY is always consistent with OUT_P after every edge.
//  PARITY_EN undefined: the PARITY port and its logic are absent; all other behaviour is identical.
// TESTING  (WIDTH=10 unless noted)
//  1. RST=1 for 2 cycles with ENABLE=1, MODE=001 -> OUT_P=0x000, BIT_CNT=0, FULL=0.
//  2. SHL with SHIFT_IN_L=1 for 10 cycles -> OUT_P=0x3FF, FULL=1 after the 10th edge;
//     an 11th SHL keeps BIT_CNT=10.
//  3. LOAD 0x2A5, then ROR once -> OUT_P=0x352, BIT_CNT=0, SHIFT_OUT_L=1, SHIFT_OUT_R=0.
//  4. LOAD 0x200, then ASR twice -> 0x300 then 0x380, BIT_CNT=2.
//  5. ENABLE=0 for 4 cycles with MODE=111 -> OUT_P and BIT_CNT are unchanged.
//  6. RST pulsed at shift 5 of an SHL burst -> OUT_P=0, BIT_CNT=0 next edge;
//     with PARITY_EN, PARITY follows ^OUT_P throughout.

Source files
------------

// File: rtl/universal_shift_register.sv
// Multi-mode shift register (shift/rotate/ASR/load/clear) with saturating shifted-bit counter; 1-cycle latency, no backpressure.
// Optional PARITY_EN adds parity_o = ^out_p_o, registered alongside the data.
module universal_shift_register #(
    parameter int               WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              CW          = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [2:0]       mode_i,
    input  logic             shift_in_l_i,
    input  logic             shift_in_r_i,
    input  logic [WIDTH-1:0] load_data_i,
    output logic [WIDTH-1:0] out_p_o,
    output logic             shift_out_l_o,
    output logic             shift_out_r_o,
    output logic [CW-1:0]    bit_cnt_o,
    output logic             full_o
`ifdef PARITY_EN
    ,
    output logic             parity_o
`endif
);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_SHL  = 3'b001,
        M_SHR  = 3'b010,
        M_ROL  = 3'b011,
        M_ROR  = 3'b100,
        M_LOAD = 3'b101,
        M_ASR  = 3'b110,
        M_CLR  = 3'b111
    } mode_e;

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shl_v, shr_v, rol_v, ror_v, asr_v;
    logic             cnt_inc, cnt_clr;

    // A 1-bit register has no neighbours: rotates and ASR degenerate to hold.
    generate
        if (WIDTH == 1) begin : g_w1
            assign shl_v = shift_in_l_i;
            assign shr_v = shift_in_r_i;
            assign rol_v = r_q;
            assign ror_v = r_q;
            assign asr_v = r_q;
        end else begin : g_wn
            assign shl_v = {r_q[WIDTH-2:0], shift_in_l_i};
            assign shr_v = {shift_in_r_i, r_q[WIDTH-1:1]};
            assign rol_v = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            assign ror_v = {r_q[0], r_q[WIDTH-1:1]};
            assign asr_v = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        r_d     = r_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        if (enable_i) begin
            case (mode_e'(mode_i))
                M_HOLD: r_d = r_q;
                M_SHL:  begin r_d = shl_v; cnt_inc = 1'b1; end
                M_SHR:  begin r_d = shr_v; cnt_inc = 1'b1; end
                M_ROL:  r_d = rol_v;
                M_ROR:  r_d = ror_v;
                M_LOAD: begin r_d = load_data_i; cnt_clr = 1'b1; end
                M_ASR:  begin r_d = asr_v; cnt_inc = 1'b1; end
                M_CLR:  begin r_d = '0; cnt_clr = 1'b1; end
                default: r_d = r_q;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_q   <= RESET_VALUE;
            cnt_q <= '0;
        end else begin
            r_q   <= r_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef PARITY_EN
    logic parity_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            parity_q <= ^RESET_VALUE;
        end else begin
            parity_q <= ^r_d;
        end
    end

    assign parity_o = parity_q;
`endif

    assign out_p_o       = r_q;
    assign shift_out_l_o = r_q[WIDTH-1];
    assign shift_out_r_o = r_q[0];
    assign bit_cnt_o     = cnt_q;
    assign full_o        = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed-vector bench for universal_shift_register (WIDTH=10); expected values queued by stimulus, checked by a monitor.
module tb_universal_shift_register;

    localparam int W  = 10;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [2:0]    mode = 3'b000;
    logic          sil = 1'b0;
    logic          sir = 1'b0;
    logic [W-1:0]  ld = '0;
    logic [W-1:0]  out_p;
    logic          sol, sor;
    logic [CW-1:0] cnt;
    logic          full;
`ifdef PARITY_EN
    logic          parity;
`endif

    always #5 clk = ~clk;

    universal_shift_register #(.WIDTH(W), .RESET_VALUE('0)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (en),
        .mode_i       (mode),
        .shift_in_l_i (sil),
        .shift_in_r_i (sir),
        .load_data_i  (ld),
        .out_p_o      (out_p),
        .shift_out_l_o(sol),
        .shift_out_r_o(sor),
        .bit_cnt_o    (cnt),
        .full_o       (full)
`ifdef PARITY_EN
        ,
        .parity_o     (parity)
`endif
    );

    typedef struct {
        int            due;
        logic [W-1:0]  out;
        logic [CW-1:0] cnt;
        logic          full;
        string         name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Apply one cycle of stimulus and queue the state expected after the next edge.
    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic sl, input logic sr, input logic [W-1:0] d,
                        input logic [W-1:0] eo, input int ec, input logic ef,
                        input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst  = r;
        en   = e;
        mode = m;
        sil  = sl;
        sir  = sr;
        ld   = d;
        x.due  = cyc + 1;
        x.out  = eo;
        x.cnt  = CW'(ec);
        x.full = ef;
        x.name = nm;
        sb.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        logic ok;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                x = sb.pop_front();
                n_cmp++;
                ok = (out_p === x.out) && (cnt === x.cnt) && (full === x.full)
                     && (sol === x.out[W-1]) && (sor === x.out[0]);
`ifdef PARITY_EN
                ok = ok && (parity === ^x.out);
`endif
                if (!ok) begin
                    n_bad++;
                    $display("FAIL %s: got out=%h cnt=%0d full=%b sol=%b sor=%b, want out=%h cnt=%0d full=%b sol=%b sor=%b",
                             x.name, out_p, cnt, full, sol, sor,
                             x.out, x.cnt, x.full, x.out[W-1], x.out[0]);
                end
            end
        end
    end

    initial begin : stim
        // reset with ENABLE/SHL active must still win
        step(1, 1, 3'b001, 1, 0, '0, 10'h000, 0, 0, "rst_a");
        step(1, 1, 3'b001, 1, 0, '0, 10'h000, 0, 0, "rst_b");

        // fill with ones, FULL on the 10th shift, saturate on the 11th
        for (int k = 0; k < W; k++) begin
            step(0, 1, 3'b001, 1, 0, '0, 10'((1 << (k + 1)) - 1), k + 1, (k == W - 1), "shl_fill");
        end
        step(0, 1, 3'b001, 1, 0, '0, 10'h3FF, 10, 1, "shl_sat");
        step(0, 1, 3'b110, 0, 0, '0, 10'h3FF, 10, 1, "asr_sat");

        step(0, 1, 3'b101, 0, 0, 10'h2A5, 10'h2A5, 0, 0, "load_2a5");
        step(0, 1, 3'b100, 0, 0, '0, 10'h352, 0, 0, "ror");

        step(0, 1, 3'b101, 0, 0, 10'h200, 10'h200, 0, 0, "load_200");
        step(0, 1, 3'b110, 0, 0, '0, 10'h300, 1, 0, "asr_1");
        step(0, 1, 3'b110, 0, 0, '0, 10'h380, 2, 0, "asr_2");

        for (int k = 0; k < 4; k++) begin
            step(0, 0, 3'b111, 1, 1, 10'h155, 10'h380, 2, 0, "en0_hold");
        end

        // direction change keeps counting
        step(0, 1, 3'b010, 0, 1, '0, 10'h3C0, 3, 0, "shr_in1");
        step(0, 1, 3'b011, 0, 0, '0, 10'h381, 3, 0, "rol");
        step(0, 1, 3'b000, 1, 1, 10'h0F0, 10'h381, 3, 0, "mode_hold");
        step(0, 1, 3'b111, 0, 0, '0, 10'h000, 0, 0, "clr");
        step(0, 1, 3'b001, 0, 0, '0, 10'h000, 1, 0, "shl_in0");
        step(0, 1, 3'b101, 0, 0, 10'h155, 10'h155, 0, 0, "load_155");
        step(0, 1, 3'b010, 0, 0, '0, 10'h0AA, 1, 0, "shr_in0");
        step(0, 1, 3'b001, 1, 0, '0, 10'h155, 2, 0, "shl_back");

        // reset pulsed in the middle of an SHL burst
        step(0, 1, 3'b111, 0, 0, '0, 10'h000, 0, 0, "clr_2");
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 3'b001, 1, 0, '0, 10'((1 << (k + 1)) - 1), k + 1, 0, "burst");
        end
        step(1, 1, 3'b001, 1, 0, '0, 10'h000, 0, 0, "rst_mid");
        step(0, 1, 3'b001, 1, 0, '0, 10'h001, 1, 0, "post_rst_1");
        step(0, 1, 3'b001, 1, 0, '0, 10'h003, 2, 0, "post_rst_2");

        @(posedge clk);
        #1;
        en = 1'b0;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
